// File: rtl/key_event_decoder.sv
// ============================================================================
// key_event_decoder : debounces the keypad scan vector and queues key presses
// Rev 1.0
// ============================================================================
`default_nettype none

module key_event_decoder #(
  parameter int DB_CYCLES  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] key,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [15:0] pressed,
  output logic        any_pressed,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int         c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [7:0] c_DB    = 8'(DB_CYCLES);
  localparam logic [7:0] c_DB_M1 = 8'(DB_CYCLES - 1);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

  logic [15:0]        r_key_s;
  logic [7:0]         r_cnt;
  logic [15:0]        r_pressed;
  logic [15:0]        r_pressed_q;
  logic [15:0]        r_pending;
  logic               r_overflow;
  logic [3:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [3:0]         r_code;
  logic               r_code_valid;

  logic               w_stable;
  logic [15:0]        w_rise;
  logic [15:0]        w_sel_mask;
  logic [3:0]         w_sel_code;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_set;
  logic [15:0]        w_pending_next;
  logic [c_PTR_W:0]   w_count_next;
  logic [c_PTR_W-1:0] w_rd_next;
  logic [3:0]         w_head_next;
  logic               unused_key0;

  assign unused_key0 = key[0];

  assign w_stable = (key[16:1] == r_key_s);
  assign w_rise   = r_pressed & ~r_pressed_q;

  // Isolate the lowest pending bit and encode its index.
  always_comb begin
    w_sel_mask = r_pending & (~r_pending + 16'd1);
    w_sel_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_sel_mask[i]) w_sel_code = 4'(i);
    end
  end

  assign w_pop  = r_code_valid & code_ready;
  assign w_push = (|r_pending) & ((r_count != c_FULL) | w_pop);

  always_comb begin
    w_pending_next = r_pending;
    if (w_push) w_pending_next = w_pending_next & ~w_sel_mask;
    w_pending_next = w_pending_next | w_rise;
    // A rise on a bit still waiting (and not leaving this clock) merges two events.
    w_ovf_set = |(w_rise & r_pending & ~(w_push ? w_sel_mask : 16'd0));
  end

  assign w_count_next = r_count + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
  assign w_rd_next    = r_rd_ptr + c_PTR_W'(w_pop);

  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_count_next == '0) w_head_next = 4'd0;
    else if (w_push && (w_rd_next == r_wr_ptr)) w_head_next = w_sel_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_s      <= '0;
      r_cnt        <= '0;
      r_pressed    <= '0;
      r_pressed_q  <= '0;
      r_pending    <= '0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_code       <= 4'd0;
      r_code_valid <= 1'b0;
    end else begin
      r_key_s <= key[16:1];
      // The edge that captures a new value is the first stable edge.
      if (!w_stable) r_cnt <= 8'd1;
      else if (r_cnt < c_DB) r_cnt <= r_cnt + 8'd1;
      if (w_stable && (r_cnt >= c_DB_M1)) r_pressed <= r_key_s;
      r_pressed_q  <= r_pressed;
      r_pending    <= w_pending_next;
      if (w_ovf_set) r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      r_rd_ptr     <= w_rd_next;
      r_count      <= w_count_next;
      r_code       <= w_head_next;
      r_code_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_sel_code;
  end

  assign code        = r_code;
  assign code_valid  = r_code_valid;
  assign pressed     = r_pressed;
  assign any_pressed = |r_pressed;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_key_event_decoder.sv
// ============================================================================
// tb_key_event_decoder : directed self-checking bench for key_event_decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_event_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] key;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] pressed;
  logic        any_pressed;
  logic        overflow;
  logic        clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_decoder #(.DB_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .pressed     (pressed),
    .any_pressed (any_pressed),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_release(input int k);
    key = 17'd1 << k;
    tick(12);
    key = '0;
    tick(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    logic seen_pressed;

    rst = 1'b1; key = '0; code_ready = 1'b0; clr_ovf = 1'b0;
    tick(2);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_any", 32'(any_pressed), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single press of key 5
    rst = 1'b0; code_ready = 1'b1; key = 17'd1 << 5;
    tick(7);
    chk("single_pressed_e7", 32'(pressed), 32'h0000);
    tick(1);
    chk("single_pressed_e8", 32'(pressed), 32'h0010);
    chk("single_any_e8", 32'(any_pressed), 32'd1);
    tick(1);
    chk("single_valid_e9", 32'(code_valid), 32'd0);
    tick(1);
    chk("single_valid_e10", 32'(code_valid), 32'd1);
    chk("single_code_e10", 32'(code), 32'd4);
    tick(1);
    chk("single_valid_e11", 32'(code_valid), 32'd0);
    key = '0;
    seen_valid = 1'b0;
    repeat (12) begin
      tick(1);
      if (code_valid) seen_valid = 1'b1;
    end
    chk("release_no_event", 32'(seen_valid), 32'd0);
    chk("release_pressed", 32'(pressed), 32'h0000);

    // Bounce on key 7: toggles every 3 clocks never reach the stable window
    seen_valid = 1'b0; seen_pressed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? (17'd1 << 7) : 17'd0;
      repeat (3) begin
        tick(1);
        if (code_valid) seen_valid = 1'b1;
        if (pressed != 16'h0) seen_pressed = 1'b1;
      end
    end
    key = '0;
    repeat (12) begin
      tick(1);
      if (code_valid) seen_valid = 1'b1;
      if (pressed != 16'h0) seen_pressed = 1'b1;
    end
    chk("bounce_no_valid", 32'(seen_valid), 32'd0);
    chk("bounce_no_pressed", 32'(seen_pressed), 32'd0);
    chk("bounce_ovf", 32'(overflow), 32'd0);

    // Simultaneous keys 3 and 10
    key = (17'd1 << 3) | (17'd1 << 10);
    tick(8);
    chk("simul_pressed", 32'(pressed), 32'h0204);
    tick(2);
    chk("simul_valid_a", 32'(code_valid), 32'd1);
    chk("simul_code_a", 32'(code), 32'd2);
    tick(1);
    chk("simul_valid_b", 32'(code_valid), 32'd1);
    chk("simul_code_b", 32'(code), 32'd9);
    tick(1);
    chk("simul_empty", 32'(code_valid), 32'd0);
    key = '0;
    tick(12);

    // Backpressure: six presses, four queued, two pending
    code_ready = 1'b0;
    for (int k = 1; k <= 6; k++) press_release(k);
    chk("bp_valid", 32'(code_valid), 32'd1);
    chk("bp_head", 32'(code), 32'd0);
    chk("bp_pending", 32'(dut.r_pending), 32'h0030);
    chk("bp_ovf", 32'(overflow), 32'd0);
    code_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      chk("bp_drain_valid", 32'(code_valid), 32'd1);
      chk("bp_drain_code", 32'(code), 32'(e));
    end
    tick(1);
    chk("bp_drain_empty", 32'(code_valid), 32'd0);
    chk("bp_drain_ovf", 32'(overflow), 32'd0);

    // Overflow: key 9 pressed twice while its first event cannot be queued
    code_ready = 1'b0;
    for (int k = 1; k <= 4; k++) press_release(k);
    press_release(9);
    chk("ovf_before_repress", 32'(overflow), 32'd0);
    key = 17'd1 << 9;
    tick(12);
    chk("ovf_set", 32'(overflow), 32'd1);
    key = '0;
    code_ready = 1'b1;
    tick(1); chk("ovf_drain_1", 32'(code), 32'd1);
    tick(1); chk("ovf_drain_2", 32'(code), 32'd2);
    tick(1); chk("ovf_drain_3", 32'(code), 32'd3);
    tick(1); chk("ovf_drain_8", 32'(code), 32'd8);
    chk("ovf_drain_8_valid", 32'(code_valid), 32'd1);
    seen_valid = 1'b0;
    repeat (4) begin
      tick(1);
      if (code_valid) seen_valid = 1'b1;
    end
    chk("ovf_single_8", 32'(seen_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    tick(8);

    // Reset mid-operation with events queued and key 12 held
    code_ready = 1'b0;
    press_release(1);
    press_release(2);
    key = 17'd1 << 12;
    tick(12);
    chk("midrst_pre_valid", 32'(code_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 32'(code_valid), 32'd0);
    chk("midrst_pressed", 32'(pressed), 32'h0000);
    chk("midrst_code", 32'(code), 32'd0);
    rst = 1'b0;
    tick(9);
    chk("midrst_valid_e9", 32'(code_valid), 32'd0);
    tick(1);
    chk("midrst_valid_e10", 32'(code_valid), 32'd1);
    chk("midrst_code_e10", 32'(code), 32'd11);
    code_ready = 1'b1;
    tick(1);
    chk("midrst_only_one", 32'(code_valid), 32'd0);
    key = '0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_event_decoder.md
# key_event_decoder

Consumer of the 17-bit scan vector produced by the 4x4 keypad scanner. It debounces the vector and detects new key presses. Each press is encoded as a 4-bit key code and buffered in a small FIFO, which the application logic (display, game FSM) drains through a valid/ready handshake. The block sits between the scanner and any logic that needs discrete key events rather than raw level bits.

## Interface
- DB_CYCLES, default 8: number of consecutive clocks the sampled vector must be unchanged before it is accepted as debounced (legal range 2..255).
- FIFO_DEPTH, default 4: key-code FIFO entries (power of two, 2..16).

- clk  in  1  system clock (same clock as the scanner).
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- key  in  17  scanner vector. key[n] = 1 means key n is pressed, for n = 1..16. key[0] is unused and ignored.
- code  out  4  key code at FIFO head; code = n-1 for key n.
- code_valid  out  1  FIFO non-empty.
- code_ready  in  1  consumer accepts the head entry.
- pressed  out  16  debounced level state; pressed[n-1] corresponds to key[n].
- any_pressed  out  1  OR of pressed.
- overflow  out  1  sticky event-loss flag.
- clr_ovf  in  1  clears overflow.

## Operation
- Sampling: key[16:1] is registered every clock into key_s. Changes are counted relative to the previous key_s.
- Debounce: stable counter cnt (8 bits).
  - Any change of key_s clears cnt.
  - Otherwise cnt saturates at DB_CYCLES.
  - pressed is loaded with key_s on the edge where key_s has been equal for DB_CYCLES consecutive edges; the capture edge counts as 1.
  - The whole vector is debounced as one unit.
- Press detection:
  - rise = pressed & ~pressed_q, where pressed_q is pressed delayed one clock.
  - Each rise bit is ORed into a 16-bit pending mask.
  - Releases produce no events.
- Encoding: each clock with pending != 0 and the FIFO not full (or being popped that same clock), the lowest set pending bit i is cleared and code i is pushed. At most one push per clock.
- FIFO:
  - Show-ahead: code is always the head entry and is valid when code_valid = 1.
  - A pop occurs on any edge with code_valid & code_ready.
  - Push and pop in the same clock are both performed. This holds when full (push allowed because of the pop) and when count = 1.
  - code_ready while empty is ignored.
- Overflow: overflow is set when a rise bit hits a pending bit that is already 1, i.e. the same key re-pressed before its previous event was enqueued. The second event is merged and lost.
  - clr_ovf clears overflow.
  - If set and clear occur in the same clock, set wins.
- Reset values: code = 0, code_valid = 0, pressed = 0, any_pressed = 0, overflow = 0. Also cleared: pending, FIFO pointers/count, cnt, key_s, pressed_q.
- Reset mid-operation: queued and pending events are discarded. Keys still held after rst deasserts are re-debounced from pressed = 0 and generate fresh press events.

## Timing
- Key vector applied before edge 1 and held steady:
  - pressed updates at edge DB_CYCLES.
  - pending set at edge DB_CYCLES+1.
  - FIFO push at edge DB_CYCLES+2.
  - code_valid = 1 after edge DB_CYCLES+2 (default: after edge 10).
- Any change within the window restarts the count at the capture edge of the new value.
- Throughput: one event per clock in each direction. Simultaneous presses of k keys appear on k consecutive clocks, lowest code first.
- code and code_valid are registered outputs with no combinational path from code_ready.
- any_pressed is combinational from pressed, so it changes in the same cycle as pressed.

## Test plan
- Single press: rst 2 clocks, key[5]=1 held, code_ready=1.
  - pressed = 0x0010 after edge 8.
  - code_valid with code = 4 after edge 10, for 1 cycle.
  - No event on release.
- Bounce: key[7] toggled every 3 clocks for 30 clocks, then released.
  - pressed stays 0; no code_valid; overflow = 0.
- Simultaneous: key[3] and key[10] asserted in the same cycle, code_ready=1.
  - Codes 2 then 9 on consecutive cycles.
  - pressed = 0x0204.
- Backpressure: code_ready=0; keys 1..6 pressed and released one at a time, each held 12 clocks.
  - code_valid stays high with head code 0.
  - 4 entries queued, pending = 0x0030.
  - code_ready=1 then yields 0,1,2,3,4,5 in order, with no loss and overflow = 0.
- Overflow: code_ready=0, FIFO filled; key 9 pressed, released, and pressed again (each phase 12 clocks).
  - overflow = 1.
  - Only one code 8 is delivered.
  - clr_ovf pulse returns overflow to 0.
- Reset mid-operation: 2 codes queued, key[12] held, rst pulsed for 1 clock.
  - code_valid = 0 after the reset edge.
  - code 11 reappears DB_CYCLES+2 edges after rst deasserts.
